mem_stage_lsu: RTL and testbench
================================

Name: mem_stage_lsu

Overview:
- Parametrised successor of the pipeline memory stage: EX/MEM-side load/store unit, internal data RAM, and MEM/WB pipeline register in one block.
- Adds byte/halfword stores with lane enables, sign/zero-extended sub-word loads, alignment and illegal-op fault detection.
- Adds a configurable multi-cycle memory latency, with a stall output to the hazard unit.
- Sits between the execute stage and the writeback mux; outputs feed writeback and forwarding.

Parameters:
- DEPTH, 256, RAM depth in 32-bit words; power of two, >=4.
- MEM_LAT, 1, cycles per memory access, 1..8; 1 = single-cycle, no stall.
- RD_BITS, 5, destination register index width.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-low reset
- valid_m  in  1  instruction in M stage is valid (0 = bubble)
- RegWriteM  in  1  instruction writes a register
- MemWriteM  in  1  store
- MemReadM  in  1  load
- ResultSrcM  in  2  00 ALU, 01 memory, 10 PC+4
- funct3_m  in  3  access size/sign, RISC-V encoding
- RD_M  in  RD_BITS  destination register
- PCPlus4M  in  32  PC+4
- WriteDataM  in  32  store data (rs2)
- ALU_ResultM  in  32  byte address / ALU result
- stall_m  out  1  holds IF..M stages; combinational
- valid_w  out  1  W-stage valid
- RegWriteW  out  1  registered write enable
- ResultSrcW  out  2  registered result select
- RD_W  out  RD_BITS  registered destination register
- PCPlus4W  out  32  registered PC+4
- ALU_ResultW  out  32  registered ALU result
- ReadDataW  out  32  registered, extended load data
- fault_w  out  1  registered fault flag for the W-stage instruction

Behaviour:
- Reset (rst=0, async):
  - All W outputs go to 0; state goes to IDLE; latency counter to 0.
  - RAM contents are NOT cleared.
  - Reset during BUSY aborts the access; a pending store is never written.
- Access decode:
  - mem_op = valid_m & (MemReadM|MemWriteM).
  - Word index = ALU_ResultM[log2(DEPTH)+1:2]; upper address bits are ignored (wrap).
- Fault conditions:
  - MemReadM & MemWriteM both set.
  - Load funct3 not in {000,001,010,100,101}.
  - Store funct3 not in {000,001,010}.
  - Halfword with addr[0]=1.
  - Word with addr[1:0]!=0.
  - On fault: no RAM access, no stall, fault_w=1 and RegWriteW=0 next cycle; other W fields are captured normally.
- Stores:
  - SB: data[7:0] replicated on all lanes, lane enable = 1<<addr[1:0].
  - SH: data[15:0] replicated, enables 0011 or 1100 by addr[1].
  - SW: all lanes.
  - Exactly one write per store, on the completing edge.
- Loads:
  - Word read, then lane select by addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- Latency FSM, states IDLE and BUSY:
  - MEM_LAT=1: the access completes on the edge it is presented; stall_m is always 0.
  - MEM_LAT=N>1, IDLE with non-faulting mem_op: stall_m=1 combinationally, go to BUSY, cnt=1.
  - BUSY: stall_m=1 while cnt<N-1, incrementing each cycle. When cnt==N-1, stall_m=0; that edge completes the access and returns to IDLE.
  - The access occupies N cycles; stall_m is high for N-1 cycles.
  - M inputs are held stable by upstream while stall_m=1; the block does not latch them.
  - Back-to-back accesses: IDLE re-enters BUSY immediately on the next mem_op.
- MEM/WB register:
  - Captures on every edge.
  - While stall_m=1, captures a bubble: valid_w=0, RegWriteW=0, fault_w=0; other fields are don't-care, driven 0.
  - Otherwise captures the M fields. valid_w=valid_m; RegWriteW=RegWriteM&valid_m&~fault.
  - ReadDataW = extended load data for loads, 0 otherwise.
- Non-memory instructions and bubbles pass through with latency 1 and never stall.

Test Plan:
- Reset mid-BUSY (MEM_LAT=4, SW addr 0x10 data 0xDEADBEEF, rst low at cycle 2):
  - All outputs 0, stall_m=0.
  - A later LW 0x10 returns the prior contents, not 0xDEADBEEF.
- MEM_LAT=1, SW 0x00000004 <- 0x80FF7F01; then LB 0x04, LBU 0x06, LH 0x06, LHU 0x06, LW 0x04:
  - ReadDataW = 0x00000001, 0x000000FF, 0xFFFF80FF, 0x000080FF, 0x80FF7F01, each one cycle after issue.
- SB 0x05 <- 0x000000AA over word 0x80FF7F01, then LW 0x04:
  - 0x80FFAA01; the other lanes are untouched.
- MEM_LAT=3, LW 0x04 issued:
  - stall_m=1 for 2 cycles, valid_w=0 during the stall.
  - Third edge gives valid_w=1 with data.
  - An ADD directly behind it passes with no extra stall.
- LH at 0x03 and SW at 0x06:
  - fault_w=1, RegWriteW=0, stall_m=0.
  - RAM is unchanged (verified by LW readback).
- Address wrap, DEPTH=256: SW 0x400 <- 0x12345678, then LW 0x000:
  - Returns 0x12345678.

Source files
------------

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: M-stage load/store unit with internal data RAM, latency FSM and MEM/WB register
module mem_stage_lsu #(
  parameter int DEPTH   = 256,
  parameter int MEM_LAT = 1,
  parameter int RD_BITS = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_m,
  input  logic               RegWriteM,
  input  logic               MemWriteM,
  input  logic               MemReadM,
  input  logic [1:0]         ResultSrcM,
  input  logic [2:0]         funct3_m,
  input  logic [RD_BITS-1:0] RD_M,
  input  logic [31:0]        PCPlus4M,
  input  logic [31:0]        WriteDataM,
  input  logic [31:0]        ALU_ResultM,
  output logic               stall_m,
  output logic               valid_w,
  output logic               RegWriteW,
  output logic [1:0]         ResultSrcW,
  output logic [RD_BITS-1:0] RD_W,
  output logic [31:0]        PCPlus4W,
  output logic [31:0]        ALU_ResultW,
  output logic [31:0]        ReadDataW,
  output logic               fault_w
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t        state;
  logic [3:0]    cnt;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] idx;
  logic [1:0]    a;
  logic          mem_op, bad_ld, bad_st, misalign, fault, access, complete;
  logic [3:0]    be;
  logic [31:0]   wd, word, lane, ext;

  assign idx      = ALU_ResultM[AW+1:2];
  assign a        = ALU_ResultM[1:0];
  assign mem_op   = valid_m & (MemReadM | MemWriteM);
  assign bad_ld   = MemReadM & !(funct3_m inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
  assign bad_st   = MemWriteM & !(funct3_m inside {3'b000, 3'b001, 3'b010});
  assign misalign = (funct3_m[1:0] == 2'b01 && a[0]) || (funct3_m[1:0] == 2'b10 && a != 2'b00);
  assign fault    = mem_op & ((MemReadM & MemWriteM) | bad_ld | bad_st | misalign);
  assign access   = mem_op & ~fault;
  // Held M inputs keep access asserted for the whole BUSY period
  assign stall_m  = MEM_LAT > 1 && access && (state == IDLE || cnt < 4'(MEM_LAT - 1));
  assign complete = access & ~stall_m;

  assign word = mem[idx];
  assign lane = word >> {a, 3'b000};
  assign ext  = funct3_m[1] ? word :
                funct3_m[0] ? {{16{lane[15] & ~funct3_m[2]}}, lane[15:0]} :
                              {{24{lane[7] & ~funct3_m[2]}}, lane[7:0]};
  assign be   = funct3_m[1] ? 4'hf : funct3_m[0] ? (a[1] ? 4'hc : 4'h3) : 4'b0001 << a;
  assign wd   = funct3_m[1] ? WriteDataM : funct3_m[0] ? {2{WriteDataM[15:0]}} : {4{WriteDataM[7:0]}};

  // RAM is never reset; a store caught by reset is simply dropped
  always_ff @(posedge clk) begin
    if (rst && complete && MemWriteM)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (state == IDLE) begin
      if (stall_m) begin
        state <= BUSY;
        cnt   <= 4'd1;
      end
    end else if (!stall_m) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      cnt <= cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst || stall_m) begin
      valid_w     <= 1'b0;
      RegWriteW   <= 1'b0;
      ResultSrcW  <= '0;
      RD_W        <= '0;
      PCPlus4W    <= '0;
      ALU_ResultW <= '0;
      ReadDataW   <= '0;
      fault_w     <= 1'b0;
    end else begin
      valid_w     <= valid_m;
      RegWriteW   <= RegWriteM & valid_m & ~fault;
      ResultSrcW  <= ResultSrcM;
      RD_W        <= RD_M;
      PCPlus4W    <= PCPlus4M;
      ALU_ResultW <= ALU_ResultM;
      ReadDataW   <= (complete & MemReadM) ? ext : 32'h0;
      fault_w     <= fault;
    end
  end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: directed checks of three instances with MEM_LAT = 1, 3 and 4
module tb_mem_stage_lsu;
  logic        clk = 0, rst = 0;
  logic        v1 = 0, v3 = 0, v4 = 0;
  logic        rw = 0, mw = 0, mr = 0;
  logic [1:0]  rs = 0;
  logic [2:0]  f3 = 0;
  logic [4:0]  rd = 5'd7;
  logic [31:0] pc = 32'h100, wdat = 0, addr = 0;
  logic        st1, st3, st4, vw1, vw3, vw4, rw1, rw3, rw4, ft1, ft3, ft4;
  logic [1:0]  rs1, rs3, rs4;
  logic [4:0]  rd1, rd3, rd4;
  logic [31:0] pc1, pc3, pc4, al1, al3, al4, dt1, dt3, dt4;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  mem_stage_lsu #(.DEPTH(256), .MEM_LAT(1)) u1 (
    .clk(clk), .rst(rst), .valid_m(v1), .RegWriteM(rw), .MemWriteM(mw), .MemReadM(mr),
    .ResultSrcM(rs), .funct3_m(f3), .RD_M(rd), .PCPlus4M(pc), .WriteDataM(wdat), .ALU_ResultM(addr),
    .stall_m(st1), .valid_w(vw1), .RegWriteW(rw1), .ResultSrcW(rs1), .RD_W(rd1), .PCPlus4W(pc1),
    .ALU_ResultW(al1), .ReadDataW(dt1), .fault_w(ft1));
  mem_stage_lsu #(.DEPTH(256), .MEM_LAT(3)) u3 (
    .clk(clk), .rst(rst), .valid_m(v3), .RegWriteM(rw), .MemWriteM(mw), .MemReadM(mr),
    .ResultSrcM(rs), .funct3_m(f3), .RD_M(rd), .PCPlus4M(pc), .WriteDataM(wdat), .ALU_ResultM(addr),
    .stall_m(st3), .valid_w(vw3), .RegWriteW(rw3), .ResultSrcW(rs3), .RD_W(rd3), .PCPlus4W(pc3),
    .ALU_ResultW(al3), .ReadDataW(dt3), .fault_w(ft3));
  mem_stage_lsu #(.DEPTH(256), .MEM_LAT(4)) u4 (
    .clk(clk), .rst(rst), .valid_m(v4), .RegWriteM(rw), .MemWriteM(mw), .MemReadM(mr),
    .ResultSrcM(rs), .funct3_m(f3), .RD_M(rd), .PCPlus4M(pc), .WriteDataM(wdat), .ALU_ResultM(addr),
    .stall_m(st4), .valid_w(vw4), .RegWriteW(rw4), .ResultSrcW(rs4), .RD_W(rd4), .PCPlus4W(pc4),
    .ALU_ResultW(al4), .ReadDataW(dt4), .fault_w(ft4));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // sel = {v4, v3, v1}
  task automatic drive(input logic [2:0] sel, input logic w, input logic s, input logic l,
                       input logic [1:0] src, input logic [2:0] f, input logic [31:0] ad,
                       input logic [31:0] d);
    {v4, v3, v1} = sel;
    rw = w; mw = s; mr = l; rs = src; f3 = f; addr = ad; wdat = d;
    #1;
  endtask

  task automatic idle();
    drive(3'b000, 0, 0, 0, 2'b00, 3'b000, 0, 0);
  endtask

  initial begin
    idle();
    step(); step();
    chk("rst_vw", {31'b0, vw4}, 0);
    chk("rst_pc", pc4, 0);
    chk("rst_stall", {31'b0, st4}, 0);
    rst = 1;
    step();

    // MEM_LAT=4: seed word 0x10, then abort a second store with reset
    drive(3'b100, 0, 1, 0, 2'b00, 3'b010, 32'h10, 32'h11112222);
    chk("l4_stall0", {31'b0, st4}, 1);
    step(); step(); step();
    chk("l4_stall_last", {31'b0, st4}, 0);
    step();
    chk("l4_sw_done", {31'b0, vw4}, 1);
    drive(3'b100, 0, 1, 0, 2'b00, 3'b010, 32'h10, 32'hDEADBEEF);
    step(); step();
    chk("l4_busy", {31'b0, st4}, 1);
    rst = 0;
    idle();
    chk("abort_vw", {31'b0, vw4}, 0);
    chk("abort_data", dt4, 0);
    chk("abort_stall", {31'b0, st4}, 0);
    step();
    rst = 1;
    step();
    drive(3'b100, 1, 0, 1, 2'b01, 3'b010, 32'h10, 0);
    step(); step(); step(); step();
    chk("abort_lw", dt4, 32'h11112222);
    chk("abort_lw_rw", {31'b0, rw4}, 1);
    idle();

    // MEM_LAT=1: sub-word loads
    drive(3'b001, 0, 1, 0, 2'b00, 3'b010, 32'h4, 32'h80FF7F01);
    chk("l1_nostall", {31'b0, st1}, 0);
    step();
    chk("l1_sw_rw", {31'b0, rw1}, 0);
    drive(3'b001, 1, 0, 1, 2'b01, 3'b000, 32'h4, 0); step(); chk("lb", dt1, 32'h00000001);
    drive(3'b001, 1, 0, 1, 2'b01, 3'b100, 32'h6, 0); step(); chk("lbu", dt1, 32'h000000FF);
    drive(3'b001, 1, 0, 1, 2'b01, 3'b001, 32'h6, 0); step(); chk("lh", dt1, 32'hFFFF80FF);
    drive(3'b001, 1, 0, 1, 2'b01, 3'b101, 32'h6, 0); step(); chk("lhu", dt1, 32'h000080FF);
    drive(3'b001, 1, 0, 1, 2'b01, 3'b010, 32'h4, 0); step(); chk("lw", dt1, 32'h80FF7F01);
    chk("lw_rd", {27'b0, rd1}, 7);
    drive(3'b001, 0, 1, 0, 2'b00, 3'b000, 32'h5, 32'h000000AA); step();
    drive(3'b001, 1, 0, 1, 2'b01, 3'b010, 32'h4, 0); step(); chk("sb_lw", dt1, 32'h80FFAA01);

    // Faults: misaligned LH and SW
    drive(3'b001, 1, 0, 1, 2'b01, 3'b001, 32'h3, 0);
    chk("lh_mis_stall", {31'b0, st1}, 0);
    step();
    chk("lh_mis_fault", {31'b0, ft1}, 1);
    chk("lh_mis_rw", {31'b0, rw1}, 0);
    chk("lh_mis_alu", al1, 32'h3);
    drive(3'b001, 1, 1, 0, 2'b00, 3'b010, 32'h6, 32'hFFFFFFFF); step();
    chk("sw_mis_fault", {31'b0, ft1}, 1);
    drive(3'b001, 1, 0, 1, 2'b01, 3'b010, 32'h4, 0); step();
    chk("fault_ram", dt1, 32'h80FFAA01);
    chk("fault_clear", {31'b0, ft1}, 0);
    drive(3'b001, 1, 1, 1, 2'b01, 3'b010, 32'h8, 0); step();
    chk("rdwr_fault", {31'b0, ft1}, 1);

    // Address wrap
    drive(3'b001, 0, 1, 0, 2'b00, 3'b010, 32'h400, 32'h12345678); step();
    drive(3'b001, 1, 0, 1, 2'b01, 3'b010, 32'h0, 0); step();
    chk("wrap", dt1, 32'h12345678);

    // MEM_LAT=3: load stalls two cycles, following ADD does not stall
    drive(3'b010, 0, 1, 0, 2'b00, 3'b010, 32'h4, 32'hCAFEF00D);
    step(); step(); step();
    drive(3'b010, 1, 0, 1, 2'b01, 3'b010, 32'h4, 0);
    chk("l3_stall0", {31'b0, st3}, 1);
    step();
    chk("l3_vw0", {31'b0, vw3}, 0);
    chk("l3_stall1", {31'b0, st3}, 1);
    step();
    chk("l3_vw1", {31'b0, vw3}, 0);
    chk("l3_stall2", {31'b0, st3}, 0);
    step();
    chk("l3_vw2", {31'b0, vw3}, 1);
    chk("l3_data", dt3, 32'hCAFEF00D);
    drive(3'b010, 1, 0, 0, 2'b00, 3'b000, 32'h55, 0);
    chk("add_nostall", {31'b0, st3}, 0);
    step();
    chk("add_vw", {31'b0, vw3}, 1);
    chk("add_rw", {31'b0, rw3}, 1);
    chk("add_alu", al3, 32'h55);
    chk("add_data", dt3, 0);
    idle();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
